// File: rtl/axis_weight_streamer_if.sv
// axis_weight_streamer_if: AXI-Stream beat bundle carrying header and weight payload
interface axis_weight_streamer_if #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8
);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  modport master (output tvalid, tlast, tdata, tkeep, input tready);
  modport slave (input tvalid, tlast, tdata, tkeep, output tready);
endinterface

// File: rtl/axis_weight_streamer.sv
// axis_weight_streamer: per command emits a config header beat, then packed weight beats fetched from memory
module axis_weight_streamer #(
  parameter int WORD_WIDTH         = 8,
  parameter int S_WEIGHTS_WIDTH_LF = 64,
  parameter int KW_MAX             = 3,
  parameter int IM_CIN_MAX         = 1024,
  parameter int IM_COLS_MAX        = 512,
  parameter int IM_ROWS_MAX        = 256,
  parameter int XN_MAX             = 64,
  parameter int BRAM_WEIGHTS_DEPTH = 1024,
  parameter int MEM_ADDR_WIDTH     = 32,
  parameter int MEM_LATENCY        = 2,
  parameter int BITS_WORDS         = 20,
  localparam int LANES     = S_WEIGHTS_WIDTH_LF / WORD_WIDTH,
  localparam int HDR_WIDTH = $clog2((KW_MAX + 1) / 2) + $clog2(IM_CIN_MAX) + $clog2(IM_COLS_MAX)
                           + $clog2(IM_ROWS_MAX) + $clog2(XN_MAX) + $clog2(BRAM_WEIGHTS_DEPTH)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          s_cmd_valid,
  output logic                          s_cmd_ready,
  input  logic [HDR_WIDTH-1:0]          s_cmd_config,
  input  logic [MEM_ADDR_WIDTH-1:0]     s_cmd_base_addr,
  input  logic [BITS_WORDS-1:0]         s_cmd_words,
  output logic                          mem_ren,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_raddr,
  input  logic [S_WEIGHTS_WIDTH_LF-1:0] mem_rdata,
  axis_weight_streamer_if.master        m_axis,
  output logic                          busy
);
  localparam int FIFO_DEPTH = MEM_LATENCY + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int LANE_W     = $clog2(LANES);
  typedef enum logic [1:0] {IDLE, HEADER, STREAM} state_t;
  state_t                        state;
  logic [HDR_WIDTH-1:0]          cfg;
  logic [MEM_ADDR_WIDTH-1:0]     base;
  logic [BITS_WORDS-1:0]         n_beats, issued, sent, cmd_beats;
  logic [LANE_W-1:0]             rem;
  logic [MEM_LATENCY-1:0]        vld;
  logic [S_WEIGHTS_WIDTH_LF-1:0] fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic [CNT_W-1:0]              fifo_count;
  logic [LANES-1:0]              keep_last;
  logic                          push, pop, last_beat, credit_ok, tvalid;
  // Beat bookkeeping, read-credit check and AXIS output muxing; outputs read as zero when idle
  always_comb begin
    cmd_beats = (s_cmd_words >> LANE_W) + BITS_WORDS'(|s_cmd_words[LANE_W-1:0]);
    push = vld[MEM_LATENCY-1];
    last_beat = sent == n_beats - BITS_WORDS'(1);
    tvalid = state == HEADER || (state == STREAM && fifo_count != '0);
    pop = state == STREAM && fifo_count != '0 && m_axis.tready;
    credit_ok = int'(fifo_count) + $countones(vld) - int'(pop) < FIFO_DEPTH;
    mem_ren = (state == HEADER || state == STREAM) && issued < n_beats && credit_ok;
    mem_raddr = mem_ren ? base + MEM_ADDR_WIDTH'(issued) : '0;
    keep_last = rem == '0 ? '1 : ~({LANES{1'b1}} << rem);
    m_axis.tvalid = tvalid;
    m_axis.tdata = state == HEADER ? S_WEIGHTS_WIDTH_LF'(cfg) : tvalid ? fifo[rd_ptr] : '0;
    m_axis.tkeep = state == HEADER ? '1 : tvalid ? (last_beat ? keep_last : '1) : '0;
    m_axis.tlast = state == HEADER ? n_beats == '0 : tvalid && last_beat;
    s_cmd_ready = aresetn && state == IDLE;
    busy = state != IDLE;
  end
  // Command FSM: latch command, send header, stream payload until the final beat handshakes
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
      cfg <= '0;
      base <= '0;
      n_beats <= '0;
      rem <= '0;
      issued <= '0;
      sent <= '0;
    end else begin
      issued <= issued + BITS_WORDS'(mem_ren);
      case (state)
        IDLE: if (s_cmd_valid) begin
          state <= HEADER;
          cfg <= s_cmd_config;
          base <= s_cmd_base_addr;
          n_beats <= cmd_beats;
          rem <= s_cmd_words[LANE_W-1:0];
          issued <= '0;
          sent <= '0;
        end
        HEADER: if (m_axis.tready) state <= n_beats == '0 ? IDLE : STREAM;
        STREAM: if (pop) begin
          sent <= sent + BITS_WORDS'(1);
          if (last_beat) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Read-valid pipeline and FIFO pointers; clearing the pipeline drops data of reads issued before reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
    end else begin
      vld[0] <= mem_ren;
      for (int i = 1; i < MEM_LATENCY; i++) vld[i] <= vld[i-1];
      if (push) wr_ptr <= wr_ptr == PTR_W'(FIFO_DEPTH - 1) ? '0 : wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr == PTR_W'(FIFO_DEPTH - 1) ? '0 : rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  // FIFO storage, written as memory data returns
  always_ff @(posedge aclk) begin
    if (push) fifo[wr_ptr] <= mem_rdata;
  end
endmodule

// File: tb/tb_axis_weight_streamer.sv
// tb_axis_weight_streamer: directed checks of header/payload streaming, credit limit, reset and back-to-back commands
module tb_axis_weight_streamer;
  logic        aclk = 0;
  logic        aresetn = 0;
  logic        s_cmd_valid = 0;
  logic        s_cmd_ready;
  logic [43:0] s_cmd_config = '0;
  logic [31:0] s_cmd_base_addr = '0;
  logic [19:0] s_cmd_words = '0;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic [63:0] mem_rdata;
  logic        busy;
  logic [31:0] a1, a2;
  int          n_cmp = 0;
  int          n_err = 0;
  int          g, m;

  always #5 aclk = ~aclk;

  axis_weight_streamer_if #(.DATA_W(64), .KEEP_W(8)) m_axis ();

  axis_weight_streamer #(
    .WORD_WIDTH(8), .S_WEIGHTS_WIDTH_LF(64), .MEM_ADDR_WIDTH(32), .MEM_LATENCY(2), .BITS_WORDS(20)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_config(s_cmd_config),
    .s_cmd_base_addr(s_cmd_base_addr), .s_cmd_words(s_cmd_words),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .m_axis(m_axis), .busy(busy)
  );

  function automatic logic [63:0] mdata(input logic [31:0] a);
    return {a ^ 32'hC3A5_5A3C, a};
  endfunction

  // Two-cycle read-only memory; keeps returning data regardless of DUT reset
  always @(posedge aclk) begin
    a1 <= mem_raddr;
    a2 <= a1;
  end
  assign mem_rdata = mdata(a2);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [43:0] cfg, input logic [31:0] base, input int words);
    int w = 0;
    s_cmd_valid = 1;
    s_cmd_config = cfg;
    s_cmd_base_addr = base;
    s_cmd_words = 20'(words);
    #1;
    while (!s_cmd_ready && w < 100) begin
      @(negedge aclk);
      #1;
      w++;
    end
    if (!s_cmd_ready) begin
      n_cmp++;
      n_err++;
      $error("FAIL cmd_accept: observed ready 0 expected 1 within 100 cycles");
    end
    @(negedge aclk);
  endtask

  // Called at the negedge after command acceptance; consumes beats until tlast (or after 'stop' payload beats)
  task automatic collect(input logic [43:0] cfg, input logic [31:0] base, input int words, input int stop,
                         input bit rnd, output int first_gap, output int max_gap);
    int nb = (words + 7) / 8;
    int rem = words % 8;
    int k = -1;
    int cyc = 0;
    int nren = 0;
    int outst = 0;
    int hdr_cyc = 0;
    int prev_cyc = 0;
    bit done = 0;
    bit hs, pop;
    logic [7:0] kl;
    kl = rem == 0 ? 8'hFF : 8'((1 << rem) - 1);
    first_gap = 0;
    max_gap = 0;
    chk("hdr_latency", m_axis.tvalid, 1);
    while (!done) begin
      if (cyc > 2000) begin
        n_cmp++;
        n_err++;
        $error("FAIL beat_timeout: observed %0d beats expected %0d", k + 1, nb + 1);
        break;
      end
      m_axis.tready = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
      #1;
      hs = m_axis.tvalid && m_axis.tready;
      pop = hs && k >= 0;
      nren += int'(mem_ren);
      outst += int'(mem_ren) - int'(pop);
      chk("credit_limit", outst <= 4, 1);
      chk("busy_not_ready", {busy, s_cmd_ready}, 2'b10);
      if (hs) begin
        if (k < 0) begin
          chk("hdr_data", m_axis.tdata, 64'(cfg));
          chk("hdr_keep", m_axis.tkeep, 8'hFF);
          chk("hdr_last", m_axis.tlast, nb == 0);
          hdr_cyc = cyc;
          done = nb == 0;
        end else begin
          chk("pay_data", m_axis.tdata, mdata(base + k));
          chk("pay_keep", m_axis.tkeep, k == nb - 1 ? kl : 8'hFF);
          chk("pay_last", m_axis.tlast, k == nb - 1);
          if (k == 0) first_gap = cyc - hdr_cyc;
          else if (cyc - prev_cyc > max_gap) max_gap = cyc - prev_cyc;
          prev_cyc = cyc;
          done = k >= nb - 1;
        end
        k++;
        if (stop > 0 && k == stop) done = 1;
      end
      @(negedge aclk);
      cyc++;
    end
    if (stop == 0) chk("n_reads", nren, nb);
  endtask

  initial begin
    m_axis.tready = 0;
    repeat (3) @(negedge aclk);
    chk("rst_axis_ctl", {m_axis.tvalid, m_axis.tlast, m_axis.tkeep}, 0);
    chk("rst_tdata", m_axis.tdata, 0);
    chk("rst_mem", {mem_ren, mem_raddr}, 0);
    chk("rst_busy_ready", {busy, s_cmd_ready}, 0);
    aresetn = 1;
    @(negedge aclk);
    chk("idle_ready", {busy, s_cmd_ready}, 2'b01);

    send_cmd(44'hABC_DEF0_1234, 32'h100, 20);
    s_cmd_valid = 0;
    collect(44'hABC_DEF0_1234, 32'h100, 20, 0, 0, g, m);
    chk("w20_first_gap", g, 3);
    chk("w20_spacing", m, 1);
    chk("w20_idle_after", {busy, s_cmd_ready}, 2'b01);

    send_cmd(44'h123_4567_89AB, 32'h40, 16);
    s_cmd_valid = 0;
    collect(44'h123_4567_89AB, 32'h40, 16, 0, 0, g, m);
    chk("w16_first_gap", g, 3);
    chk("w16_spacing", m, 1);
    chk("w16_idle_after", {busy, s_cmd_ready}, 2'b01);

    send_cmd(44'h0F0_F0F0_F0F0, 32'h1000, 200);
    s_cmd_valid = 0;
    collect(44'h0F0_F0F0_F0F0, 32'h1000, 200, 0, 1, g, m);

    send_cmd(44'hFFF_0000_0001, 32'h2000, 0);
    s_cmd_valid = 0;
    collect(44'hFFF_0000_0001, 32'h2000, 0, 0, 0, g, m);
    chk("w0_idle_after", {busy, s_cmd_ready}, 2'b01);

    send_cmd(44'h555_AAAA_5555, 32'h200, 64);
    s_cmd_valid = 0;
    collect(44'h555_AAAA_5555, 32'h200, 64, 2, 0, g, m);
    aresetn = 0;
    @(negedge aclk);
    chk("mid_rst_axis_ctl", {m_axis.tvalid, m_axis.tlast, m_axis.tkeep}, 0);
    chk("mid_rst_tdata", m_axis.tdata, 0);
    chk("mid_rst_mem", {mem_ren, mem_raddr}, 0);
    chk("mid_rst_busy_ready", {busy, s_cmd_ready}, 0);
    aresetn = 1;
    @(negedge aclk);
    chk("post_rst_ready", {busy, s_cmd_ready}, 2'b01);
    send_cmd(44'h777_1357_9BDF, 32'h300, 8);
    s_cmd_valid = 0;
    collect(44'h777_1357_9BDF, 32'h300, 8, 0, 0, g, m);
    chk("post_rst_first_gap", g, 3);

    send_cmd(44'h111_2222_3333, 32'h500, 8);
    s_cmd_config = 44'h444_5555_6666;
    s_cmd_base_addr = 32'h600;
    s_cmd_words = 20'd12;
    collect(44'h111_2222_3333, 32'h500, 8, 0, 0, g, m);
    chk("b2b_ready_after_tlast", {busy, s_cmd_ready}, 2'b01);
    @(negedge aclk);
    s_cmd_valid = 0;
    collect(44'h444_5555_6666, 32'h600, 12, 0, 0, g, m);
    chk("b2b_idle_after", {busy, s_cmd_ready}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
